// File: rtl/apb_periodic_scheduler.sv
// N_CH periodic channels arbitrated round-robin into a single APB write master.
// Optional READBACK_EN: each successful write is verified by an APB read of the same address.
module apb_periodic_scheduler #(
  parameter int                N_CH        = 4,
  parameter int                CNT_W       = 32,
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 12'h100,
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = 12'h010,
  parameter int                TIMEOUT_CYC = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   enable,
  input  logic [N_CH*CNT_W-1:0]  period_cfg,
  output logic [ADDR_W-1:0]      m_apb_paddr,
  output logic                   m_apb_psel,
  output logic                   m_apb_penable,
  output logic                   m_apb_pwrite,
  output logic [DATA_W-1:0]      m_apb_pwdata,
  output logic [DATA_W/8-1:0]    m_apb_pstrb,
  input  logic                   m_apb_pready,
  input  logic                   m_apb_pslverr,
  input  logic [DATA_W-1:0]      m_apb_prdata,
`ifdef READBACK_EN
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_valid,
`endif
  output logic                   busy,
  output logic [N_CH-1:0]        sent_pulse,
  output logic [15:0]            drop_cnt,
  output logic                   err_sticky,
  output logic [2:0]             err_ch
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0]  cnt     [N_CH];
  logic [DATA_W-1:0] payload [N_CH];
  logic [N_CH-1:0]   pend, expire, clr, drop;
  logic [CH_W-1:0]   ptr, cur, gnt;
  logic [DATA_W-1:0] gnt_data;
  logic [TW-1:0]     tmo_cnt;
  logic [16:0]       drop_sum;
  logic              rd_phase;
  logic              tmo_hit, done, ok, to_read, fin, fin_ok, fin_err;

  always_comb begin
    tmo_hit = (state == ACCESS) && !m_apb_pready && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
    done    = (state == ACCESS) && (m_apb_pready || tmo_hit);
    ok      = done && m_apb_pready && !m_apb_pslverr;
`ifdef READBACK_EN
    // the write phase hands over to the read phase; the channel finishes on the read
    to_read = ok && !rd_phase;
    fin     = done && !to_read;
    fin_ok  = ok && rd_phase;
    fin_err = (done && !ok) || (fin_ok && (m_apb_prdata != m_apb_pwdata));
`else
    to_read = 1'b0;
    fin     = done;
    fin_ok  = ok;
    fin_err = done && !ok;
`endif
  end

  always_comb begin
    logic [2*N_CH-1:0] rot;
    int unsigned       g;
    rot = {pend, pend} >> ptr;
    g   = 0;
    // descending scan so the lowest rotated offset wins
    for (int unsigned k = N_CH; k > 0; k--) begin
      if (rot[k-1]) begin
        g = 32'(ptr) + k - 1;
        if (g >= N_CH) g = g - N_CH;
      end
    end
    gnt      = CH_W'(g);
    gnt_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (CH_W'(i) == gnt) gnt_data = payload[i];
    end
  end

  always_comb begin
    expire   = '0;
    clr      = '0;
    drop     = '0;
    drop_sum = {1'b0, drop_cnt};
    for (int unsigned i = 0; i < N_CH; i++) begin
      expire[i] = enable && (period_cfg[i*CNT_W +: CNT_W] != '0) &&
                  (cnt[i] == period_cfg[i*CNT_W +: CNT_W] - 1'b1);
      clr[i]    = fin && (CH_W'(i) == cur);
      drop[i]   = expire[i] && pend[i] && !clr[i];
      drop_sum  = drop_sum + 17'(drop[i]);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    m_apb_psel    = 1'b0;
    m_apb_penable = 1'b0;
    m_apb_pwrite  = 1'b0;
    case (state)
      IDLE:   if (|pend) state_nxt = SETUP;
      SETUP: begin
        m_apb_psel   = 1'b1;
        m_apb_pwrite = !rd_phase;
        state_nxt    = ACCESS;
      end
      ACCESS: begin
        m_apb_psel    = 1'b1;
        m_apb_penable = 1'b1;
        m_apb_pwrite  = !rd_phase;
        if (done) state_nxt = to_read ? SETUP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    m_apb_pstrb = {(DATA_W/8){m_apb_pwrite}};
    busy        = (state != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt[i]     <= '0;
        payload[i] <= '0;
      end
      pend         <= '0;
      ptr          <= '0;
      cur          <= '0;
      m_apb_paddr  <= '0;
      m_apb_pwdata <= '0;
      tmo_cnt      <= '0;
      sent_pulse   <= '0;
      drop_cnt     <= '0;
      err_sticky   <= 1'b0;
      err_ch       <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        // a shrunk period restarts the counter without an expiry
        if (enable) begin
          if (expire[i] || (cnt[i] >= period_cfg[i*CNT_W +: CNT_W])) cnt[i] <= '0;
          else                                                       cnt[i] <= cnt[i] + 1'b1;
        end
        if (clr[i] && fin_ok) payload[i] <= payload[i] + 1'b1;
      end
      pend       <= expire | (pend & ~clr);
      drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      sent_pulse <= fin_ok ? clr : '0;
      tmo_cnt    <= (state == ACCESS && !done) ? tmo_cnt + 1'b1 : '0;
      if (state == IDLE && |pend) begin
        cur          <= gnt;
        m_apb_paddr  <= BASE_ADDR + ADDR_W'(gnt) * ADDR_STRIDE;
        m_apb_pwdata <= gnt_data;
      end
      if (fin) begin
        if (int'(cur) == N_CH - 1) ptr <= '0;
        else                       ptr <= cur + 1'b1;
      end
      if (fin_err) begin
        err_sticky <= 1'b1;
        err_ch     <= 3'(cur);
      end
    end
  end

`ifdef READBACK_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_phase <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= fin_ok;
      if (fin_ok) rd_data <= m_apb_prdata;
      if (to_read)  rd_phase <= 1'b1;
      else if (fin) rd_phase <= 1'b0;
    end
  end
`else
  logic prdata_unused;
  assign rd_phase      = 1'b0;
  assign prdata_unused = ^m_apb_prdata;
`endif

endmodule

// File: tb/tb_apb_periodic_scheduler.sv
// Randomized/directed bench for apb_periodic_scheduler against a cycle-level behavioural model.
module tb_apb_periodic_scheduler;
  localparam int N  = 4;
  localparam int TO = 64;

  logic          CLK = 1'b0;
  logic          RST, enable;
  logic [N*32-1:0] period_cfg;
  logic [11:0]   m_apb_paddr;
  logic          m_apb_psel, m_apb_penable, m_apb_pwrite;
  logic [31:0]   m_apb_pwdata;
  logic [3:0]    m_apb_pstrb;
  logic          m_apb_pready, m_apb_pslverr;
  logic [31:0]   m_apb_prdata;
  logic          busy;
  logic [N-1:0]  sent_pulse;
  logic [15:0]   drop_cnt;
  logic          err_sticky;
  logic [2:0]    err_ch;

  apb_periodic_scheduler #(.N_CH(N), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .RST(RST), .enable(enable), .period_cfg(period_cfg),
    .m_apb_paddr(m_apb_paddr), .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable),
    .m_apb_pwrite(m_apb_pwrite), .m_apb_pwdata(m_apb_pwdata), .m_apb_pstrb(m_apb_pstrb),
    .m_apb_pready(m_apb_pready), .m_apb_pslverr(m_apb_pslverr), .m_apb_prdata(m_apb_prdata),
    .busy(busy), .sent_pulse(sent_pulse), .drop_cnt(drop_cnt),
    .err_sticky(err_sticky), .err_ch(err_ch)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int pr_mode, err_mode;

  // model: ages of period counters, pending set, transfer stage (0 idle, 1 setup, 2 access)
  int unsigned m_age [N];
  logic [31:0] m_pay [N];
  logic [N-1:0] m_pend, m_sent;
  int m_stage, m_acc, m_cur, m_ptr, m_errch;
  int unsigned m_drop;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      if (failures <= 40) $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_age[i] = 0; m_pay[i] = 0; end
    m_pend = '0; m_sent = '0; m_stage = 0; m_acc = 0; m_cur = 0; m_ptr = 0;
    m_errch = 0; m_drop = 0; m_err = 0;
  endtask

  task automatic model_advance();
    logic [N-1:0] ex, cl;
    bit done, ok;
    int unsigned nd, cfg;
    if (RST) begin model_reset(); return; end
    done = 0; ok = 0; ex = '0; cl = '0; nd = 0;
    if (m_stage == 2) begin
      m_acc++;
      if (m_apb_pready) begin done = 1; ok = !m_apb_pslverr; end
      else if (m_acc == TO) done = 1;
    end
    for (int i = 0; i < N; i++) begin
      cfg = period_cfg[i*32 +: 32];
      if (enable) begin
        if (cfg == 0 || m_age[i] >= cfg) m_age[i] = 0;
        else if (m_age[i] == cfg - 1) begin ex[i] = 1'b1; m_age[i] = 0; end
        else m_age[i]++;
      end
    end
    m_sent = '0;
    case (m_stage)
      0: if (|m_pend) begin
           for (int k = N - 1; k >= 0; k--)
             if (m_pend[(m_ptr + k) % N]) m_cur = (m_ptr + k) % N;
           m_stage = 1;
         end
      1: begin m_stage = 2; m_acc = 0; end
      default: if (done) begin
           cl[m_cur] = 1'b1;
           if (ok) begin m_sent[m_cur] = 1'b1; m_pay[m_cur] = m_pay[m_cur] + 1; end
           else begin m_err = 1; m_errch = m_cur; end
           m_ptr = (m_cur + 1) % N;
           m_stage = 0;
         end
    endcase
    for (int i = 0; i < N; i++) begin
      if (ex[i] && m_pend[i] && !cl[i]) nd++;
      m_pend[i] = ex[i] | (m_pend[i] & ~cl[i]);
    end
    m_drop = (m_drop + nd > 32'hFFFF) ? 32'hFFFF : m_drop + nd;
  endtask

  task automatic compare_outputs();
    check("psel",    32'(m_apb_psel),    32'(m_stage != 0));
    check("penable", 32'(m_apb_penable), 32'(m_stage == 2));
    check("pwrite",  32'(m_apb_pwrite),  32'(m_stage != 0));
    check("busy",    32'(busy),          32'(m_stage != 0));
    check("pstrb",   32'(m_apb_pstrb),   (m_stage != 0) ? 32'hF : 32'h0);
    if (m_stage != 0) begin
      check("paddr",  32'(m_apb_paddr), 32'(12'h100 + m_cur * 16));
      check("pwdata", m_apb_pwdata,     m_pay[m_cur]);
    end
    check("sent_pulse", 32'(sent_pulse), 32'(m_sent));
    check("drop_cnt",   32'(drop_cnt),   m_drop);
    check("err_sticky", 32'(err_sticky), 32'(m_err));
    check("err_ch",     32'(err_ch),     32'(m_errch));
  endtask

  task automatic drive_handshake();
    case (pr_mode)
      0:       m_apb_pready = 1'b1;
      1:       m_apb_pready = (m_stage == 2 && m_acc >= 8);
      2:       m_apb_pready = 1'b0;
      default: m_apb_pready = ($urandom_range(99) < 75);
    endcase
    case (err_mode)
      0:       m_apb_pslverr = 1'b0;
      1:       m_apb_pslverr = (m_stage == 2 && m_cur == 2);
      default: m_apb_pslverr = ($urandom_range(99) < 10);
    endcase
  endtask

  // inputs for the coming cycle are already set; model and DUT advance together
  task automatic step();
    drive_handshake();
    model_advance();
    @(posedge CLK);
    @(negedge CLK);
    compare_outputs();
  endtask

  task automatic set_cfg(input int ch, input int unsigned v);
    period_cfg[ch*32 +: 32] = v;
  endtask

  task automatic phase_reset();
    RST = 1'b1; enable = 1'b0; period_cfg = '0; pr_mode = 0; err_mode = 0;
    step(); step();
    RST = 1'b0;
  endtask

  initial begin
    int n, cnt0, cnt2;
    logic [11:0] addrs [$];
    bit hit;

    RST = 1'b1; enable = 1'b0; period_cfg = '0;
    m_apb_pready = 1'b0; m_apb_pslverr = 1'b0; m_apb_prdata = '0;
    pr_mode = 0; err_mode = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    compare_outputs();
    check("rst_paddr",  32'(m_apb_paddr), 32'h0);
    check("rst_pwdata", m_apb_pwdata,     32'h0);
    phase_reset();

    // single channel, period 10, always ready
    set_cfg(0, 10); enable = 1'b1;
    cnt0 = 0;
    for (int i = 0; i < 65; i++) begin step(); if (sent_pulse[0]) cnt0++; end
    check("a_sent_count", 32'(cnt0), 32'd6);

    // all channels period 20: same-cycle expiry, rotating grants
    phase_reset();
    for (int c = 0; c < N; c++) set_cfg(c, 20);
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (m_apb_psel && !m_apb_penable) addrs.push_back(m_apb_paddr);
    end
    check("b_grant_count", 32'(addrs.size()), 32'd16);
    for (int i = 0; i < 8 && i < addrs.size(); i++)
      check("b_grant_addr", 32'(addrs[i]), 32'(12'h100 + (i % 4) * 16));

    // period 3 with slow slave: drops accumulate
    phase_reset();
    set_cfg(0, 3); enable = 1'b1; pr_mode = 1;
    repeat (80) step();
    check("c_drop_nonzero", 32'(drop_cnt != 0), 32'd1);

    // slave never ready: timeout after TO access cycles, then the next channel is serviced
    phase_reset();
    set_cfg(1, 50); set_cfg(2, 50); enable = 1'b1; pr_mode = 2;
    hit = 0;
    for (int i = 0; i < 100 && !hit; i++) begin step(); hit = m_apb_penable; end
    check("d_reached_access", 32'(hit), 32'd1);
    n = 0;
    for (int i = 0; i < 200 && m_apb_penable; i++) begin n++; step(); end
    check("d_access_cycles", 32'(n), 32'(TO));
    check("d_err_sticky", 32'(err_sticky), 32'd1);
    check("d_err_ch",     32'(err_ch),     32'd1);
    check("d_idle",       32'(busy),       32'd0);
    pr_mode = 0;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin step(); hit = sent_pulse[2]; end
    check("d_next_channel", 32'(hit), 32'd1);

    // slave error on channel 2
    phase_reset();
    for (int c = 0; c < N; c++) set_cfg(c, 15);
    enable = 1'b1; err_mode = 1;
    cnt0 = 0; cnt2 = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (sent_pulse[0]) cnt0++;
      if (sent_pulse[2]) cnt2++;
    end
    check("e_sent2_none", 32'(cnt2), 32'd0);
    check("e_sent0_some", 32'(cnt0 > 0), 32'd1);
    check("e_err_ch",     32'(err_ch), 32'd2);

    // reset while in ACCESS
    phase_reset();
    set_cfg(0, 5); enable = 1'b1; pr_mode = 2;
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin step(); hit = (m_stage == 2); end
    check("r_reached_access", 32'(hit), 32'd1);
    step();
    RST = 1'b1;
    step();
    check("r_psel",    32'(m_apb_psel),    32'd0);
    check("r_penable", 32'(m_apb_penable), 32'd0);
    check("r_paddr",   32'(m_apb_paddr),   32'd0);
    check("r_pwdata",  m_apb_pwdata,       32'd0);
    check("r_sent",    32'(sent_pulse),    32'd0);
    RST = 1'b0;

    // drop counter saturation
    phase_reset();
    for (int c = 0; c < N; c++) set_cfg(c, 1);
    enable = 1'b1; pr_mode = 2;
    repeat (17500) step();
    check("s_drop_sat", 32'(drop_cnt), 32'hFFFF);

    // random traffic, enable toggling, period changes
    phase_reset();
    for (int c = 0; c < N; c++) set_cfg(c, $urandom_range(30, 1));
    enable = 1'b1; pr_mode = 3; err_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(99) < 5) enable = ~enable;
      if ($urandom_range(99) < 2) set_cfg($urandom_range(N - 1), $urandom_range(40));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_periodic_scheduler.md
Name: apb_periodic_scheduler

Overview:
Multi-channel successor to the single-counter periodic sender in the CAN-FD top level. Each of N_CH channels owns a runtime-programmable period counter and a wrapping payload counter. Expired channels are arbitrated round-robin into a single APB master. The APB master performs a fully handshaked SETUP/ACCESS write into a CAN-FD core (e.g. per-channel TX buffer address), with PREADY timeout and error reporting.

Parameters:
N_CH, 4, number of periodic channels (1..8)
CNT_W, 32, width of period counters and period_cfg fields
DATA_W, 32, APB data and payload width
ADDR_W, 12, APB address width
BASE_ADDR, 12'h100, APB address of channel 0
ADDR_STRIDE, 12'h010, address step per channel
TIMEOUT_CYC, 64, maximum ACCESS cycles waiting for PREADY

Ports:
CLK  in  1  single clock; all logic rising-edge
RST  in  1  synchronous, active-high reset
enable  in  1  global run; low freezes period counters
period_cfg  in  N_CH*CNT_W  per-channel period in cycles; field 0 = channel disabled
m_apb_paddr  out  ADDR_W  BASE_ADDR + ch*ADDR_STRIDE
m_apb_psel  out  1  APB select
m_apb_penable  out  1  APB enable
m_apb_pwrite  out  1  1 for writes
m_apb_pwdata  out  DATA_W  channel payload
m_apb_pstrb  out  DATA_W/8  all ones on writes
m_apb_pready  in  1  slave ready
m_apb_pslverr  in  1  slave error
m_apb_prdata  in  DATA_W  read data (used only with READBACK_EN)
busy  out  1  FSM not IDLE
sent_pulse  out  N_CH  one-cycle pulse per successful write
drop_cnt  out  16  saturating count of periods lost while still pending
err_sticky  out  1  set on PSLVERR or timeout; cleared only by RST
err_ch  out  3  channel of most recent error

Behaviour:
- Reset is synchronous and active-high. All counters, pending flags, payloads, drop_cnt and err_sticky reset to 0. err_ch resets to 0. The round-robin pointer resets to channel 0. All APB outputs reset to 0. busy and sent_pulse reset to 0.
- RST asserted mid-transfer aborts the transfer immediately: psel/penable go low on the next edge, and no sent_pulse is generated.
- Period counter: when enable=1 and period_cfg[ch]!=0, the counter counts 0..period_cfg-1 and then wraps to 0. The expiry event occurs in the cycle where counter==period_cfg-1.
- period_cfg=1 produces an expiry every cycle.
- enable=0 holds the counters. Pending flags are preserved, and any in-flight transfer completes.
- Changing period_cfg applies on the next compare. If the counter is already >= the new value, the counter is reset to 0 without an expiry.
- Pending: set on the cycle after expiry. Cleared on completion of that channel's transfer, whether OK or error.
- If expiry coincides with completion on the same channel, pending stays set and no drop is counted.
- If expiry hits an already-pending, non-completing channel, drop_cnt increments. drop_cnt saturates at 16'hFFFF.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if any pending flag is set, grant the first pending channel at or after the round-robin pointer, wrapping. Latch paddr/pwdata and go to SETUP.
- SETUP: psel=1, penable=0, pwrite=1. Next state is ACCESS.
- ACCESS: psel=1, penable=1. When pready=1, the transfer completes:
  - if pslverr=0, pulse sent_pulse[ch] and increment payload[ch] (wraps at 2^DATA_W);
  - if pslverr=1, payload is unchanged, err_sticky=1 and err_ch=ch.
  - In both cases drop psel/penable and return to IDLE. The pointer advances to ch+1.
- ACCESS timeout: if TIMEOUT_CYC cycles pass without pready, abort as an error (err_sticky, err_ch, pending cleared, payload unchanged) and return to IDLE.
- APB address, data and control are stable from SETUP through completion.
- Minimum latency: expiry at cycle t, pending at t+1, SETUP at t+2, ACCESS at t+3. Completion occurs at t+3 if pready is high.
- Back-to-back transfers insert one IDLE cycle.

Optional Feature:
READBACK_EN:
- When defined, each successful write is followed by an APB read (SETUP/ACCESS, pwrite=0) at the same address, with the same timeout rules.
- Adds outputs rd_data (DATA_W) and rd_valid (1-cycle pulse).
- sent_pulse fires at read completion.
- A mismatch between rd_data and the written payload sets err_sticky.
- When undefined, there are no read cycles, rd_* ports are absent, and m_apb_prdata is ignored.

Test Plan:
- N_CH=1, period_cfg=10, pready tied 1 -> writes at paddr 12'h100 every 10 cycles; pwdata = 0,1,2,...; exactly one sent_pulse per write.
- 4 channels, all period_cfg=20 -> same-cycle expiry; grants in order 0,1,2,3; addresses 100/110/120/130; subsequent rounds rotate fairly.
- period_cfg[0]=3, pready held low 8 cycles per transfer -> drop_cnt increments; payload advances only on completion; no lost APB handshake.
- pready never asserted, TIMEOUT_CYC=64 -> abort after 64 ACCESS cycles; err_sticky=1; err_ch=granted channel; FSM back to IDLE; next channel serviced.
- pslverr=1 on channel 2 -> payload[2] unchanged, err_ch=2, no sent_pulse[2]; RST mid-ACCESS -> all outputs 0 on the next edge.
- READBACK_EN, prdata returns pwdata^1 -> rd_valid pulse, err_sticky=1; with matching prdata -> no error, sent_pulse after the read.
